// File: rtl/alu_unit.sv
// Registered N-bit unsigned calculator ALU.
// Every operation is computed in parallel; result picks one per cycle.
module alu_unit #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [2:0]     op,
  input  logic           op_sum,
  input  logic           op_subt,
  output logic [N-1:0]   result,
  output logic [N-1:0]   sumResult,
  output logic [N-1:0]   subResult,
  output logic [N-1:0]   diviResult,
  output logic [N-1:0]   moduResult,
  output logic [N-1:0]   andResult,
  output logic [N-1:0]   orResult,
  output logic [2*N-1:0] multiResult,
  output logic           carryingSum,
  output logic           carryingSub
);

  logic [N:0]     sum_full;
  logic [N:0]     sub_full;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo;
  logic [N:0]     rem;
  logic [2:0]     code;
  logic [N-1:0]   sel;

  assign sum_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign prod     = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  assign code     = ~op;

  // Restoring divider; b=0 naturally yields all-ones quotient, remainder a.
  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      rem = {rem[N-1:0], a[i]};
      if (rem >= {1'b0, b}) begin
        rem    = rem - {1'b0, b};
        quo[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel = sum_full[N-1:0];
    if (op_sum) begin
      sel = sum_full[N-1:0];
    end else if (op_subt) begin
      sel = sub_full[N-1:0];
    end else begin
      unique case (code)
        3'd0:    sel = sum_full[N-1:0];
        3'd1:    sel = sub_full[N-1:0];
        3'd2:    sel = prod[N-1:0];
        3'd3:    sel = quo;
        3'd4:    sel = rem[N-1:0];
        3'd5:    sel = a & b;
        3'd6:    sel = a | b;
        default: sel = a ^ b;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      sumResult   <= '0;
      subResult   <= '0;
      diviResult  <= '0;
      moduResult  <= '0;
      andResult   <= '0;
      orResult    <= '0;
      multiResult <= '0;
      carryingSum <= 1'b0;
      carryingSub <= 1'b0;
    end else begin
      result      <= sel;
      sumResult   <= sum_full[N-1:0];
      subResult   <= sub_full[N-1:0];
      diviResult  <= quo;
      moduResult  <= rem[N-1:0];
      andResult   <= a & b;
      orResult    <= a | b;
      multiResult <= prod;
      carryingSum <= sum_full[N];
      carryingSub <= sub_full[N];
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed plan steps plus random
// stimulus against an integer-arithmetic reference model.
module tb_alu_unit;
  localparam int N = 4;
  localparam int M = 1 << N;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   a, b;
  logic [2:0]     op;
  logic           op_sum, op_subt;
  logic [N-1:0]   result, sumResult, subResult;
  logic [N-1:0]   diviResult, moduResult;
  logic [N-1:0]   andResult, orResult;
  logic [2*N-1:0] multiResult;
  logic           carryingSum, carryingSub;

  int errors = 0;
  int checks = 0;

  alu_unit #(.N(N)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
    .op_sum(op_sum), .op_subt(op_subt),
    .result(result), .sumResult(sumResult),
    .subResult(subResult), .diviResult(diviResult),
    .moduResult(moduResult), .andResult(andResult),
    .orResult(orResult), .multiResult(multiResult),
    .carryingSum(carryingSum), .carryingSub(carryingSub)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".result"}, 32'(result), 0);
    check({tag, ".sum"}, 32'(sumResult), 0);
    check({tag, ".sub"}, 32'(subResult), 0);
    check({tag, ".div"}, 32'(diviResult), 0);
    check({tag, ".mod"}, 32'(moduResult), 0);
    check({tag, ".and"}, 32'(andResult), 0);
    check({tag, ".or"}, 32'(orResult), 0);
    check({tag, ".mul"}, 32'(multiResult), 0);
    check({tag, ".cs"}, 32'(carryingSum), 0);
    check({tag, ".cb"}, 32'(carryingSub), 0);
  endtask

  // Reference model from plain integer arithmetic.
  task automatic check_model(input string tag,
                             input int ia, input int ib,
                             input int iop, input int s,
                             input int t);
    int sm, sb, dv, md, pr, code, r;
    sm   = (ia + ib) % M;
    sb   = (ia - ib + M) % M;
    dv   = (ib == 0) ? M - 1 : ia / ib;
    md   = (ib == 0) ? ia : ia % ib;
    pr   = ia * ib;
    code = 7 - iop;
    case (code)
      0: r = sm;
      1: r = sb;
      2: r = pr % M;
      3: r = dv;
      4: r = md;
      5: r = ia & ib;
      6: r = ia | ib;
      default: r = ia ^ ib;
    endcase
    if (s != 0) r = sm;
    else if (t != 0) r = sb;
    check({tag, ".result"}, 32'(result), r);
    check({tag, ".sum"}, 32'(sumResult), sm);
    check({tag, ".sub"}, 32'(subResult), sb);
    check({tag, ".div"}, 32'(diviResult), dv);
    check({tag, ".mod"}, 32'(moduResult), md);
    check({tag, ".and"}, 32'(andResult), ia & ib);
    check({tag, ".or"}, 32'(orResult), ia | ib);
    check({tag, ".mul"}, 32'(multiResult), pr);
    check({tag, ".cs"}, 32'(carryingSum),
          (ia + ib >= M) ? 1 : 0);
    check({tag, ".cb"}, 32'(carryingSub),
          (ia < ib) ? 1 : 0);
  endtask

  task automatic step(input string tag,
                      input int ia, input int ib,
                      input int iop, input int s,
                      input int t);
    @(negedge clk);
    rst     = 1'b0;
    a       = N'(ia);
    b       = N'(ib);
    op      = 3'(iop);
    op_sum  = s[0];
    op_subt = t[0];
    @(posedge clk);
    #1;
    check_model(tag, ia, ib, iop, s, t);
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0;
    op = 3'b111; op_sum = 1'b0; op_subt = 1'b0;

    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end

    step("add_div0", 4'b1000, 4'b0000, 3'b111, 0, 0);
    check("add_div0.lit_res", 32'(result), 4'b1000);
    check("add_div0.lit_div", 32'(diviResult), 4'b1111);
    check("add_div0.lit_mod", 32'(moduResult), 4'b1000);

    step("sub", 4'b1001, 4'b1001, 3'b110, 0, 0);
    check("sub.lit_res", 32'(result), 0);
    step("mul", 4'b1010, 4'b0010, 3'b101, 0, 0);
    check("mul.lit_res", 32'(result), 4'b0100);
    check("mul.lit_mul", 32'(multiResult), 8'b00010100);
    step("div", 4'b1011, 4'b1011, 3'b100, 0, 0);
    check("div.lit_res", 32'(result), 4'b0001);
    step("mod", 4'b1011, 4'b0011, 3'b011, 0, 0);
    check("mod.lit_res", 32'(result), 4'b0010);
    step("and", 4'b1000, 4'b1000, 3'b010, 0, 0);
    check("and.lit_res", 32'(result), 4'b1000);
    step("or", 4'b1010, 4'b0101, 3'b001, 0, 0);
    check("or.lit_res", 32'(result), 4'b1111);
    step("xor", 4'b1000, 4'b1000, 3'b000, 0, 0);
    check("xor.lit_res", 32'(result), 0);

    step("fsum", 4'b1111, 4'b1000, 3'b111, 1, 0);
    check("fsum.lit_res", 32'(result), 4'b0111);
    check("fsum.lit_cs", 32'(carryingSum), 1);
    step("fboth", 4'b1111, 4'b1000, 3'b111, 1, 1);
    check("fboth.lit_res", 32'(result), 4'b0111);
    step("fsub0", 4'b1111, 4'b1111, 3'b111, 0, 1);
    check("fsub0.lit_cb", 32'(carryingSub), 0);
    step("fsub1", 4'b1000, 4'b1111, 3'b111, 0, 1);
    check("fsub1.lit_res", 32'(result), 4'b1001);
    check("fsub1.lit_cb", 32'(carryingSub), 1);
    step("ovr_xor", 4'b0110, 4'b0011, 3'b000, 0, 1);

    // Latency: a changes every cycle.
    for (int i = 0; i < M; i++)
      step("lat", i, 5, 3'b111, 0, 0);

    // Inputs moving between edges must not show.
    step("hold", 4'b0111, 4'b0010, 3'b100, 0, 0);
    a = 4'b0001; b = 4'b0000; op = 3'b000;
    op_sum = 1'b1;
    #2;
    check_model("hold_mid", 4'b0111, 4'b0010,
                3'b100, 0, 0);

    for (int i = 0; i < 300; i++)
      step("rand", int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 1 : 0,
           ($urandom_range(0, 3) == 0) ? 1 : 0);

    // Mid-stream reset with live inputs.
    @(negedge clk);
    rst = 1'b1; a = 4'b1101; b = 4'b0110;
    op = 3'b101; op_sum = 1'b0; op_subt = 1'b0;
    @(posedge clk);
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    check_zero("mid_rst_hold");
    step("post_rst", 4'b1101, 4'b0110, 3'b101, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
